// File: rtl/serdes_lane_serializer.sv
// serdes_lane_serializer: takes one N_SAMPLES-word frame per recv handshake
// and emits it as BEATS = N_SAMPLES/N_LANES beats of N_LANES words each.
// A new frame can load on the same edge the final beat is consumed, so
// back-to-back frames stream with no idle cycle.
// Optional build macro SERDES_SER_LAST_EN adds the send_last output.
// recv_rdy depends combinationally on send_rdy while on the final beat.
module serdes_lane_serializer #(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned N_SAMPLES = 8,
  parameter int unsigned N_LANES   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES],
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic [BIT_WIDTH-1:0] send_msg [N_LANES],
  output logic                 send_val,
  input  logic                 send_rdy
`ifdef SERDES_SER_LAST_EN
  ,
  output logic                 send_last
`endif
);

  localparam int unsigned LANES_SAFE = (N_LANES == 0) ? 1 : N_LANES;
  localparam int unsigned BEATS      = N_SAMPLES / LANES_SAFE;
  localparam int unsigned BW         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned IW         = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  // Reject lane counts that cannot evenly split a frame.
  if (N_LANES < 1 || (N_SAMPLES % LANES_SAFE) != 0) begin : g_param_check
    $error("serdes_lane_serializer: need N_LANES >= 1 and N_SAMPLES %% N_LANES == 0");
  end

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [BIT_WIDTH-1:0] data_q [N_SAMPLES];
  logic                 load;
  logic                 last_beat;

  assign last_beat = (beat_q == LAST_BEAT);

  // State and beat counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Frame storage: all samples captured together on a load.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_SAMPLES; i++) begin
      if (reset) begin
        data_q[i] <= '0;
      end else if (load) begin
        data_q[i] <= recv_msg[i];
      end
    end
  end

  // Next-state, handshake and beat sequencing; outputs forced low in reset.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    load     = 1'b0;
    recv_rdy = 1'b0;
    send_val = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          recv_rdy = 1'b1;
          if (recv_val) begin
            load    = 1'b1;
            beat_d  = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          send_val = 1'b1;
          recv_rdy = send_rdy && last_beat;
          if (send_rdy) begin
            if (!last_beat) begin
              beat_d = beat_q + BW'(1);
            end else if (recv_val) begin
              // Final beat consumed and next frame taken on the same edge.
              load   = 1'b1;
              beat_d = '0;
            end else begin
              beat_d  = '0;
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          beat_d  = '0;
        end
      endcase
    end
  end

  // Lane mux: lane l shows sample beat*N_LANES + l of the held frame.
  always_comb begin
    for (int unsigned l = 0; l < N_LANES; l++) begin
      send_msg[l] = data_q[IW'(32'(beat_q) * N_LANES + l)];
    end
  end

`ifdef SERDES_SER_LAST_EN
  assign send_last = send_val && last_beat;
`endif

endmodule

// File: tb/tb_serdes_lane_serializer.sv
// Testbench for serdes_lane_serializer: three configurations (BEATS=4,
// BEATS=3, BEATS=1) checked cycle by cycle against a frame/queue model.
module tb_serdes_lane_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rv = 1'b0;
  logic        sr = 1'b1;
  int          sel = 0;
  logic [31:0] frame [8];

  logic [31:0] in_a [8];
  logic [31:0] in_b [6];
  logic [31:0] in_c [8];
  logic [31:0] out_a [2];
  logic [31:0] out_b [2];
  logic [31:0] out_c [8];
  logic        val_in_a, val_in_b, val_in_c;
  logic        rdy_in_a, rdy_in_b, rdy_in_c;
  logic        rdy_a, rdy_b, rdy_c;
  logic        val_a, val_b, val_c;
`ifdef SERDES_SER_LAST_EN
  logic        last_a, last_b, last_c;
`endif

  logic        obs_rdy, obs_val, obs_last;
  logic [31:0] obs_msg [8];

  int          errors = 0;
  int          checks = 0;

  logic [31:0] q[$];
  int          rem = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      in_a[i] = frame[i];
      in_c[i] = frame[i];
    end
    for (int i = 0; i < 6; i++) in_b[i] = frame[i];
  end

  assign val_in_a = rv && (sel == 0);
  assign val_in_b = rv && (sel == 1);
  assign val_in_c = rv && (sel == 2);
  assign rdy_in_a = (sel == 0) ? sr : 1'b1;
  assign rdy_in_b = (sel == 1) ? sr : 1'b1;
  assign rdy_in_c = (sel == 2) ? sr : 1'b1;

  serdes_lane_serializer #(.BIT_WIDTH(32), .N_SAMPLES(8), .N_LANES(2)) dut_a (
    .clk(clk), .reset(reset), .recv_msg(in_a), .recv_val(val_in_a), .recv_rdy(rdy_a),
    .send_msg(out_a), .send_val(val_a), .send_rdy(rdy_in_a)
`ifdef SERDES_SER_LAST_EN
    , .send_last(last_a)
`endif
  );

  serdes_lane_serializer #(.BIT_WIDTH(32), .N_SAMPLES(6), .N_LANES(2)) dut_b (
    .clk(clk), .reset(reset), .recv_msg(in_b), .recv_val(val_in_b), .recv_rdy(rdy_b),
    .send_msg(out_b), .send_val(val_b), .send_rdy(rdy_in_b)
`ifdef SERDES_SER_LAST_EN
    , .send_last(last_b)
`endif
  );

  serdes_lane_serializer #(.BIT_WIDTH(32), .N_SAMPLES(8), .N_LANES(8)) dut_c (
    .clk(clk), .reset(reset), .recv_msg(in_c), .recv_val(val_in_c), .recv_rdy(rdy_c),
    .send_msg(out_c), .send_val(val_c), .send_rdy(rdy_in_c)
`ifdef SERDES_SER_LAST_EN
    , .send_last(last_c)
`endif
  );

  // Route the selected instance's outputs to a common observation point.
  always_comb begin
    obs_rdy  = 1'b0;
    obs_val  = 1'b0;
    obs_last = 1'b0;
    for (int i = 0; i < 8; i++) obs_msg[i] = '0;
    case (sel)
      0: begin
        obs_rdy = rdy_a; obs_val = val_a;
        for (int i = 0; i < 2; i++) obs_msg[i] = out_a[i];
`ifdef SERDES_SER_LAST_EN
        obs_last = last_a;
`endif
      end
      1: begin
        obs_rdy = rdy_b; obs_val = val_b;
        for (int i = 0; i < 2; i++) obs_msg[i] = out_b[i];
`ifdef SERDES_SER_LAST_EN
        obs_last = last_b;
`endif
      end
      default: begin
        obs_rdy = rdy_c; obs_val = val_c;
        for (int i = 0; i < 8; i++) obs_msg[i] = out_c[i];
`ifdef SERDES_SER_LAST_EN
        obs_last = last_c;
`endif
      end
    endcase
  end

  function automatic int samples_of(input int s);
    return (s == 1) ? 6 : 8;
  endfunction

  function automatic int lanes_of(input int s);
    return (s == 2) ? 8 : 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic set_frame(input logic [31:0] base);
    for (int i = 0; i < 8; i++) frame[i] = base + 32'(i);
  endtask

  // One clock cycle: drive inputs, compare at negedge, advance the model.
  // Model: rem = beats still owed, q = samples still owed in output order.
  task automatic cycle(input logic v, input logic r);
    logic ev, er;
    int   nl, ns;
    nl = lanes_of(sel);
    ns = samples_of(sel);
    rv = v;
    sr = r;
    @(negedge clk);
    ev = (rem > 0);
    er = (rem == 0) || (rem == 1 && r);
    chk("send_val", 32'(obs_val), 32'(ev));
    chk("recv_rdy", 32'(obs_rdy), 32'(er));
`ifdef SERDES_SER_LAST_EN
    chk("send_last", 32'(obs_last), 32'(ev && rem == 1));
`endif
    if (ev) begin
      for (int l = 0; l < nl; l++) chk("send_msg", obs_msg[l], q[l]);
    end
    if (ev && r) begin
      for (int l = 0; l < nl; l++) void'(q.pop_front());
      rem--;
    end
    if (v && er) begin
      for (int i = 0; i < ns; i++) q.push_back(frame[i]);
      rem += ns / nl;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    while (rem > 0) cycle(1'b0, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rv    = 1'b1;
    sr    = 1'b1;
    @(negedge clk);
    chk("rst_recv_rdy", 32'(obs_rdy), 32'd0);
    chk("rst_send_val", 32'(obs_val), 32'd0);
`ifdef SERDES_SER_LAST_EN
    chk("rst_send_last", 32'(obs_last), 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    rv    = 1'b0;
    rem   = 0;
    q.delete();
    @(negedge clk);
    chk("post_rst_recv_rdy", 32'(obs_rdy), 32'd1);
    chk("post_rst_send_val", 32'(obs_val), 32'd0);
    for (int l = 0; l < lanes_of(sel); l++) chk("post_rst_send_msg", obs_msg[l], 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_frame(32'h0);
    sel = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Basic frame 0x10..0x17.
    set_frame(32'h10);
    cycle(1'b1, 1'b1);
    repeat (4) cycle(1'b0, 1'b1);

    // Backpressure on beats 2-4: frame occupies 7 cycles.
    set_frame(32'h30);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b1);

    // Back-to-back A0.. then B0.. with recv_val held high.
    set_frame(32'hA0);
    cycle(1'b1, 1'b1);
    set_frame(32'hB0);
    repeat (4) cycle(1'b1, 1'b1);
    repeat (4) cycle(1'b0, 1'b1);

    // Stall on the final beat keeps recv_rdy low and the next frame waiting.
    set_frame(32'hC0);
    cycle(1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b1);
    set_frame(32'hD0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    drain();

    // Reset after beat 1 drops the frame; new frame starts clean.
    set_frame(32'h50);
    cycle(1'b1, 1'b1);
    repeat (2) cycle(1'b0, 1'b1);
    do_reset();
    set_frame(32'h20);
    cycle(1'b1, 1'b1);
    drain();

    // Randomized traffic on each configuration.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      do_reset();
      if (s != 0) begin
        set_frame(32'h60);
        cycle(1'b1, 1'b1);
        repeat (2 * samples_of(s) / lanes_of(s)) cycle(1'b1, 1'b1);
        drain();
      end
      repeat (300) begin
        for (int i = 0; i < 8; i++) frame[i] = $urandom;
        cycle(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 70));
      end
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
